// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the uart_tx_arbiter block and its helpers.
//
// Contents:
//   arb_state_e  - transfer sequencer states (IDLE, START, WAIT_BUSY, WAIT_DONE)
//   idx_width()  - width of an index into n items, never less than 1 bit
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

  // $clog2(1) is 0, which would give zero-width vectors; clamp to 1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte producers, the arbiter and the uart_tx instance.
//
// Handshake: requester i raises req[i] (a level) with its byte on
// req_data[i*W +: W] and holds both until it sees the one-cycle gnt[i]
// pulse; gnt[i] means the byte has been copied, so req and data may change
// from the following cycle. tx_start is a one-cycle pulse to uart_tx with
// tx_data held stable; tx_busy comes back high for the duration of the frame.
//
// Signals:
//   req      N    producer -> arbiter  request levels
//   req_data N*W  producer -> arbiter  packed bytes
//   gnt      N    arbiter -> producer  one-hot accept pulse
//   tx_data  W    arbiter -> uart_tx   byte to send
//   tx_start 1    arbiter -> uart_tx   start pulse
//   tx_busy  1    uart_tx -> arbiter   frame in progress
//   owner    idx  arbiter -> system    last granted requester
//   err      1    arbiter -> system    timeout abort pulse
// Modports: master = producers/uart side, slave = arbiter.
interface uart_tx_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int IW = uart_tx_arbiter_pkg::idx_width(N);

  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic [W-1:0]   tx_data;
  logic           tx_start;
  logic           tx_busy;
  logic [IW-1:0]  owner;
  logic           err;

  modport master (
    output req, req_data, tx_busy,
    input  gnt, tx_data, tx_start, owner, err
  );

  modport slave (
    input  req, req_data, tx_busy,
    output gnt, tx_data, tx_start, owner, err
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
// Returns the first set bit of req at or after index ptr, wrapping modulo N.
//
// Ports:
//   req  in  N   request vector
//   ptr  in  IW  highest-priority index this round
//   pick out N   one-hot of the chosen index (0 when nothing requests)
//   idx  out IW  chosen index (0 when nothing requests)
//   any  out 1   at least one request present
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          any
);

  int            cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    pick     = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N; k++) begin
      cand     = (int'(ptr) + k) % N;
      cand_idx = IW'(cand);
      if (!any && req[cand_idx]) begin
        any            = 1'b1;
        pick[cand_idx] = 1'b1;
        idx            = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx among N byte requesters, round-robin.
// Each transfer: grant + latch byte (IDLE), pulse tx_start (START), wait for
// tx_busy to rise (WAIT_BUSY), wait for it to fall (WAIT_DONE).
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   bus        slave modport of uart_tx_arbiter_if (req/req_data/gnt/tx_*/owner/err)
//   state_dbg  out  current sequencer state
//   ptr_dbg    out  current round-robin pointer
//
// Build option: define UART_ARB_TIMEOUT_EN to abort a transfer whose tx_busy
// never rises within TIMEOUT cycles of START (err pulses, back to IDLE).
// Without it err is constant 0 and WAIT_BUSY waits indefinitely.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 1024,
  localparam int IW     = idx_width(N)
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus,
  output arb_state_e        state_dbg,
  output logic [IW-1:0]     ptr_dbg
);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [W-1:0]  tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic          err_q, err_d;

  logic [N-1:0]  pick;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          grant_now;
  logic [W-1:0]  picked_byte;
  logic [IW-1:0] ptr_next;

  rr_picker #(.N(N), .IW(IW)) u_picker (
    .req  (bus.req),
    .ptr  (ptr_q),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // A busy transmitter in IDLE is someone else's frame (or a stale one);
  // never start on top of it. rst gates gnt because it is combinational.
  assign grant_now = (state_q == ST_IDLE) && pick_any && !bus.tx_busy && !rst;

  always_comb begin
    picked_byte = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) picked_byte = bus.req_data[i*W +: W];
    end
  end

  assign ptr_next = (int'(pick_idx) == N - 1) ? '0 : pick_idx + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = idx_width(TIMEOUT + 1);
  // Counts cycles since START; START itself loads 1.
  logic [CW-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    err_d      = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_now) begin
          state_d    = ST_START;
          tx_data_d  = picked_byte;
          owner_d    = pick_idx;
          ptr_d      = ptr_next;
          tx_start_d = 1'b1;
        end
      end
      ST_START: begin
        state_d = ST_WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
        tmo_d   = CW'(1);
`endif
      end
      ST_WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = ST_WAIT_DONE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        // Abort decided TIMEOUT-1 cycles after START so err lands exactly
        // TIMEOUT cycles after START. Pointer already moved past the owner.
        else if (tmo_q == CW'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      err_q      <= err_d;
`ifdef UART_ARB_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign bus.gnt      = grant_now ? pick : '0;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.owner    = owner_q;
  assign bus.err      = err_q;
  assign state_dbg    = state_q;
  assign ptr_dbg      = ptr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (N=4, W=8, TIMEOUT=16).
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int N        = 4;
  localparam int W        = 8;
  localparam int TMO      = 16;
  localparam int BUSY_LEN = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_arbiter_if #(.N(N), .W(W)) bus();
  arb_state_e state_dbg;
  logic [1:0] ptr_dbg;

  uart_tx_arbiter #(.N(N), .W(W), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg),
    .ptr_dbg   (ptr_dbg)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [1:0]   exp_own_q[$];
  logic [W-1:0] data_of[N];

  task automatic expect_xfer(input int idx);
    exp_q.push_back(data_of[idx]);
    exp_own_q.push_back(2'(idx));
  endtask

  task automatic set_data(input int idx, input logic [W-1:0] b);
    data_of[idx] = b;
    bus.req_data[idx*W +: W] = b;
  endtask

  // ---------------- uart_tx busy model ----------------
  // Raises tx_busy 0..2 cycles after tx_start and holds it BUSY_LEN cycles.
  logic auto_busy = 1'b1;
  int   dly_cnt   = -1;
  int   hold_cnt  = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (auto_busy) begin
        if (rst) begin
          dly_cnt     = -1;
          hold_cnt    = 0;
          bus.tx_busy = 1'b0;
        end else begin
          if (hold_cnt > 0) begin
            hold_cnt--;
            if (hold_cnt == 0) bus.tx_busy = 1'b0;
          end else if (dly_cnt > 0) begin
            dly_cnt--;
          end
          if (bus.tx_start && dly_cnt < 0 && hold_cnt == 0)
            dly_cnt = int'($urandom_range(0, 2));
          if (dly_cnt == 0) begin
            bus.tx_busy = 1'b1;
            hold_cnt    = BUSY_LEN;
            dly_cnt     = -1;
          end
        end
      end
    end
  end

  // ---------------- monitor (samples on negedge) ----------------
  logic [N-1:0] gnt_prev  = '0;
  logic [W-1:0] last_data = '0;
  int n_gnt = 0, n_start = 0, n_err = 0, start_cyc = 0, err_cyc = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.gnt != '0) begin
        n_gnt++;
        check_eq("gnt_onehot", 32'($onehot(bus.gnt)), 1);
        if (exp_own_q.size() > 0) check_eq("gnt_idx", bus.gnt, 32'(4'b0001 << exp_own_q[0]));
        else check_eq("gnt_unexpected", bus.gnt, 0);
      end
      if (bus.tx_start) begin
        n_start++;
        start_cyc = cyc;
        last_data = bus.tx_data;
        check_eq("start_latency", 32'(gnt_prev != '0), 1);
        if (exp_q.size() > 0) begin
          check_eq("tx_data", bus.tx_data, exp_q.pop_front());
          check_eq("owner", bus.owner, exp_own_q.pop_front());
        end else begin
          check_eq("start_unexpected", exp_q.size(), 1);
        end
      end
      if (state_dbg == ST_WAIT_DONE && !bus.tx_busy)
        check_eq("tx_data_hold", bus.tx_data, last_data);
      if (bus.err) begin
        n_err++;
        err_cyc = cyc;
      end
    end
    gnt_prev = bus.gnt;
  end

  // ---------------- driver helpers ----------------
  task automatic wait_grants(input int n, input int budget, input string tag);
    int base = n_gnt;
    int c = 0;
    while ((n_gnt - base) < n && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    check_eq(tag, n_gnt - base, n);
    @(posedge clk); #1;
  endtask

  task automatic wait_state(input arb_state_e s, input int budget, input string tag);
    int c = 0;
    while (state_dbg != s && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_eq(tag, state_dbg, s);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int c = 0;
    while (!(state_dbg == ST_IDLE && !bus.tx_busy) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_eq(tag, state_dbg, ST_IDLE);
    @(posedge clk); #1;
  endtask

  task automatic check_all_clear(input string tag);
    check_eq({tag, "_state"}, state_dbg, ST_IDLE);
    check_eq({tag, "_ptr"}, ptr_dbg, 0);
    check_eq({tag, "_outs"}, {bus.gnt, bus.tx_start, bus.tx_data, bus.owner, bus.err}, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int s0;
    bus.req     = '0;
    bus.tx_busy = 1'b0;
    for (int i = 0; i < N; i++) set_data(i, 8'(8'h10 + i));

    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_clear("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of WAIT_DONE
    expect_xfer(0);
    bus.req = 4'b0001;
    wait_grants(1, 20, "t1_gnt");
    bus.req = 4'b0001;
    wait_state(ST_WAIT_DONE, 40, "t1_reach_wait_done");
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_all_clear("t1_midrst");
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    expect_xfer(1);
    bus.req = 4'b0010;
    wait_grants(1, 20, "t1_after_rst_gnt");
    bus.req = '0;
    check_eq("t1_owner", bus.owner, 1);
    wait_idle(60, "t1_idle");

    // Single requester with its own byte
    set_data(2, 8'hA5);
    s0 = n_start;
    expect_xfer(2);
    bus.req = 4'b0100;
    wait_grants(1, 20, "t2_gnt");
    bus.req = '0;
    wait_idle(60, "t2_idle");
    check_eq("t2_one_start", n_start - s0, 1);
    set_data(2, 8'h12);

    // Skip and wrap from pointer 3
    check_eq("t3_ptr_start", ptr_dbg, 3);
    expect_xfer(0);
    expect_xfer(2);
    bus.req = 4'b0101;
    wait_grants(1, 20, "t3_gnt0");
    bus.req = 4'b0100;
    wait_grants(1, 60, "t3_gnt2");
    bus.req = '0;
    wait_idle(60, "t3_idle_a");
    for (int k = 0; k < 3; k++) expect_xfer(0);
    bus.req = 4'b0001;
    wait_grants(3, 150, "t3_gnt0_repeat");
    bus.req = '0;
    wait_idle(60, "t3_idle_b");
    check_eq("t3_ptr_end", ptr_dbg, 1);

    // Busy held in IDLE blocks the grant
    auto_busy   = 1'b0;
    bus.tx_busy = 1'b1;
    bus.req     = 4'b0001;
    s0 = n_gnt;
    repeat (5) @(negedge clk);
    #1;
    check_eq("t4_blocked", n_gnt - s0, 0);
    check_eq("t4_blocked_state", state_dbg, ST_IDLE);
    expect_xfer(0);
    @(posedge clk); #1;
    auto_busy   = 1'b1;
    bus.tx_busy = 1'b0;
    @(negedge clk); #1;
    check_eq("t4_gnt_after_release", n_gnt - s0, 1);
    @(posedge clk); #1;
    bus.req = '0;
    wait_idle(60, "t4_idle");

    // Full round-robin from a fresh reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) set_data(i, 8'(8'h10 + i));
    for (int k = 0; k < 5; k++) expect_xfer(k % N);
    bus.req = 4'b1111;
    wait_grants(5, 200, "t5_rr_gnts");
    bus.req = '0;
    wait_idle(60, "t5_idle");

    // Transmitter never goes busy
    auto_busy   = 1'b0;
    bus.tx_busy = 1'b0;
    expect_xfer(1);
    bus.req = 4'b0010;
    wait_grants(1, 20, "t6_gnt");
    bus.req = '0;
`ifdef UART_ARB_TIMEOUT_EN
    s0 = 0;
    while (n_err == 0 && s0 < 40) begin
      @(negedge clk); #1;
      s0++;
    end
    check_eq("t6_err_seen", n_err, 1);
    check_eq("t6_err_delay", err_cyc - start_cyc, TMO);
    check_eq("t6_err_state", state_dbg, ST_IDLE);
    @(negedge clk); #1;
    check_eq("t6_err_pulse", bus.err, 0);
    @(posedge clk); #1;
    auto_busy = 1'b1;
    expect_xfer(2);
    bus.req = 4'b0110;
    wait_grants(1, 20, "t6_next_gnt");
    bus.req = '0;
    wait_idle(60, "t6_idle");
`else
    repeat (40) @(negedge clk);
    #1;
    check_eq("t6_stuck_state", state_dbg, ST_WAIT_BUSY);
    check_eq("t6_no_err", n_err, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    auto_busy = 1'b1;
`endif

    check_eq("final_starts_eq_gnts", n_start, n_gnt);
    check_eq("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
